// File: rtl/alu_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : alu_op_sequencer                                              |
// | Description: Accepts one ALU operation at a time over valid/ready, drives  |
// |              the ALU input-mux select (persist/load/reset) and the one-hot |
// |              output-mux select, waits the op latency, captures the result  |
// |              and returns it over a valid/ready response channel.           |
// | Ports      : clk, rst_n         clock / async active-low reset             |
// |              req_valid/ready    request handshake, req_op, req_chain       |
// |              alu_in_sel         {persist,load,reset}, 000 = hold           |
// |              alu_out_sel        {and,or,not,xor,add,sub,mult} one-hot      |
// |              alu_result/ovf     ALU outputs sampled on last EXEC cycle     |
// |              rsp_valid/ready    response handshake, rsp_data/ovf/err       |
// |              busy, ops_done     status, saturating response counter        |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module alu_op_sequencer #(
  parameter int WIDTH     = 8,
  parameter int LOGIC_LAT = 1,
  parameter int MUL_LAT   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic             req_chain,
  output logic [2:0]       alu_in_sel,
  output logic [6:0]       alu_out_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic             busy,
  output logic [15:0]      ops_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [2:0] OP_MULT = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  // Counter runs LAT-1 down to 0, so EXEC lasts exactly LAT cycles.
  localparam logic [3:0] LOGIC_CNT = 4'(LOGIC_LAT - 1);
  localparam logic [3:0] MUL_CNT   = 4'(MUL_LAT - 1);

  localparam logic [2:0] IN_HOLD    = 3'b000;
  localparam logic [2:0] IN_PERSIST = 3'b100;
  localparam logic [2:0] IN_LOAD    = 3'b010;
  localparam logic [2:0] IN_RESET   = 3'b001;

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             chain_q, chain_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             prev_valid_q, prev_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_err_q, rsp_err_d;
  logic [15:0]      ops_done_q, ops_done_d;

  // A chained request needs a result left in the ALU by a completed op.
  logic chain_err;
  assign chain_err = chain_q && !prev_valid_q && (op_q != OP_CLR);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= 3'd0;
      chain_q      <= 1'b0;
      cnt_q        <= 4'd0;
      prev_valid_q <= 1'b0;
      rsp_data_q   <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
      ops_done_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      chain_q      <= chain_d;
      cnt_q        <= cnt_d;
      prev_valid_q <= prev_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_err_q    <= rsp_err_d;
      ops_done_q   <= ops_done_d;
    end
  end

  // Next-state and datapath-register logic
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    chain_d      = chain_q;
    cnt_d        = cnt_q;
    prev_valid_d = prev_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_err_d    = rsp_err_q;
    ops_done_d   = ops_done_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          chain_d = req_chain;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (op_q == OP_CLR) begin
          rsp_data_d   = '0;
          rsp_ovf_d    = 1'b0;
          rsp_err_d    = 1'b0;
          prev_valid_d = 1'b0;
          state_d      = ST_RESP;
        end else if (chain_err) begin
          rsp_data_d = '0;
          rsp_ovf_d  = 1'b0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          cnt_d   = (op_q == OP_MULT) ? MUL_CNT : LOGIC_CNT;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d   = alu_result;
          rsp_ovf_d    = alu_overflow && (op_q == OP_MULT);
          rsp_err_d    = 1'b0;
          prev_valid_d = 1'b1;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin // ST_RESP
        if (rsp_ready) begin
          rsp_ovf_d = 1'b0;
          rsp_err_d = 1'b0;
          if (ops_done_q != 16'hFFFF) begin
            ops_done_d = ops_done_q + 16'd1;
          end
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Output decode (Moore: driven only from registered state)
  logic [6:0] op_onehot;
  always_comb begin
    op_onehot   = 7'b0000000;
    alu_in_sel  = IN_HOLD;
    alu_out_sel = 7'b0000000;
    case (op_q)
      3'd0:    op_onehot = 7'b1000000;
      3'd1:    op_onehot = 7'b0100000;
      3'd2:    op_onehot = 7'b0010000;
      3'd3:    op_onehot = 7'b0001000;
      3'd4:    op_onehot = 7'b0000100;
      3'd5:    op_onehot = 7'b0000010;
      3'd6:    op_onehot = 7'b0000001;
      default: op_onehot = 7'b0000000;
    endcase
    if (state_q == ST_LOAD) begin
      if (op_q == OP_CLR) begin
        alu_in_sel = IN_RESET;
      end else if (!chain_err) begin
        alu_in_sel  = chain_q ? IN_PERSIST : IN_LOAD;
        // Output mux set already in LOAD so a persist reloads the selected op's value.
        alu_out_sel = op_onehot;
      end
    end else if (state_q == ST_EXEC) begin
      alu_out_sel = op_onehot;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_err   = rsp_err_q;
  assign ops_done  = ops_done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_alu_op_sequencer                                           |
// | Description: Directed self-checking bench for alu_op_sequencer.            |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic       req_chain;
  logic [2:0] alu_in_sel;
  logic [6:0] alu_out_sel;
  logic [7:0] alu_result;
  logic       alu_overflow;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_ovf;
  logic       rsp_err;
  logic       busy;
  logic [15:0] ops_done;

  alu_op_sequencer #(.WIDTH(8), .LOGIC_LAT(1), .MUL_LAT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_chain    (req_chain),
    .alu_in_sel   (alu_in_sel),
    .alu_out_sel  (alu_out_sel),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_ovf      (rsp_ovf),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .ops_done     (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  logic [15:0] exp_ops = 16'd0;

  // Results of the most recent run_op
  int         lat;
  logic [2:0] load_sel;
  logic [6:0] load_out;
  int         exec_n;
  logic [6:0] exec_sel;
  logic [7:0] got_data;
  logic       got_ovf;
  logic       got_err;
  int         seen_valid;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one request, then follow it until rsp_valid (sampled on falling edges).
  // lat = falling edges after the accept edge until rsp_valid is seen (0 = timeout).
  task automatic run_op(input logic [2:0] op, input logic chain, input logic [7:0] res, input logic ovf);
    @(negedge clk);
    alu_result   = res;
    alu_overflow = ovf;
    req_valid    = 1'b1;
    req_op       = op;
    req_chain    = chain;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 3'($urandom_range(0, 7));
    req_chain = 1'($urandom_range(0, 1));
    lat = 0; exec_n = 0; exec_sel = 7'd0; load_sel = 3'd7; load_out = 7'h7F;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat      = cyc;
        got_data = rsp_data;
        got_ovf  = rsp_ovf;
        got_err  = rsp_err;
        break;
      end
      if (cyc == 1) begin
        load_sel = alu_in_sel;
        load_out = alu_out_sel;
      end else if (alu_out_sel != 7'd0) begin
        exec_n++;
        exec_sel = alu_out_sel;
      end
    end
    if (rsp_ready && lat != 0) exp_ops = (exp_ops == 16'hFFFF) ? exp_ops : exp_ops + 16'd1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_chain = 1'b0;
    alu_result = 8'd0; alu_overflow = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    // Reset values
    check_val("rst_req_ready", req_ready, 1);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_in_sel", alu_in_sel, 3'b000);
    check_val("rst_out_sel", alu_out_sel, 7'd0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ops_done", ops_done, 0);
    check_val("rst_rsp_data", rsp_data, 0);
    rst_n = 1'b1;

    // Chained request with no previous result -> error at T+2
    run_op(3'd4, 1'b1, 8'hAA, 1'b0);
    check_val("err_lat", lat, 2);
    check_val("err_in_sel", load_sel, 3'b000);
    check_val("err_out_sel", load_out, 7'd0);
    check_val("err_flag", got_err, 1);
    check_val("err_data", got_data, 8'h00);

    // ADD, fresh operands
    run_op(3'd4, 1'b0, 8'h0F, 1'b0);
    check_val("add_lat", lat, 3);
    check_val("add_in_sel", load_sel, 3'b010);
    check_val("add_load_out", load_out, 7'b0000100);
    check_val("add_exec_n", exec_n, 1);
    check_val("add_data", got_data, 8'h0F);
    check_val("add_ovf", got_ovf, 0);
    check_val("add_err", got_err, 0);

    // XOR chained onto the ADD result
    run_op(3'd3, 1'b1, 8'h3C, 1'b0);
    check_val("xor_in_sel", load_sel, 3'b100);
    check_val("xor_out_sel", exec_sel, 7'b0001000);
    check_val("xor_err", got_err, 0);
    check_val("xor_data", got_data, 8'h3C);

    // MULT with overflow
    run_op(3'd6, 1'b0, 8'h90, 1'b1);
    check_val("mul_lat", lat, 6);
    check_val("mul_exec_n", exec_n, 4);
    check_val("mul_out_sel", exec_sel, 7'b0000001);
    check_val("mul_data", got_data, 8'h90);
    check_val("mul_ovf", got_ovf, 1);

    // Overflow input ignored for non-MULT ops
    run_op(3'd1, 1'b0, 8'hF0, 1'b1);
    check_val("or_out_sel", exec_sel, 7'b0100000);
    check_val("or_ovf", got_ovf, 0);
    @(negedge clk);
    check_val("ops_after_5", ops_done, exp_ops);

    // Back-pressure: response held, second request refused
    rsp_ready = 1'b0;
    run_op(3'd5, 1'b0, 8'h55, 1'b0);
    check_val("sub_lat", lat, 3);
    req_valid = 1'b1; req_op = 3'd0; req_chain = 1'b0;
    alu_result = 8'h11;
    seen_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_data == 8'h55 && !req_ready) seen_valid++;
    end
    check_val("stall_stable", seen_valid, 5);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    exp_ops = exp_ops + 16'd1;
    @(negedge clk);
    check_val("stall_release_valid", rsp_valid, 0);
    check_val("stall_no_accept", busy, 0);
    check_val("stall_ops", ops_done, exp_ops);

    // CLR, then a chained op must error
    run_op(3'd7, 1'b0, 8'h77, 1'b0);
    check_val("clr_lat", lat, 2);
    check_val("clr_in_sel", load_sel, 3'b001);
    check_val("clr_data", got_data, 8'h00);
    run_op(3'd0, 1'b1, 8'h66, 1'b0);
    check_val("clr_chain_err", got_err, 1);

    // Reset in the middle of a MULT
    @(negedge clk);
    alu_result = 8'hC3; req_valid = 1'b1; req_op = 3'd6; req_chain = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("mid_exec_sel", alu_out_sel, 7'b0000001);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_out_sel", alu_out_sel, 7'd0);
    check_val("mid_rst_req_ready", req_ready, 1);
    check_val("mid_rst_ops", ops_done, 0);
    exp_ops = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) seen_valid++;
    end
    check_val("mid_rst_no_rsp", seen_valid, 0);

    // Saturation of ops_done
    @(negedge clk);
    dut.ops_done_q = 16'hFFFE;
    exp_ops = 16'hFFFE;
    run_op(3'd4, 1'b0, 8'h01, 1'b0);
    @(negedge clk);
    check_val("sat_first", ops_done, 16'hFFFF);
    run_op(3'd4, 1'b0, 8'h02, 1'b0);
    run_op(3'd4, 1'b0, 8'h03, 1'b0);
    @(negedge clk);
    check_val("sat_third", ops_done, 16'hFFFF);
    check_val("sat_model", ops_done, exp_ops);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
